// File: rtl/fsm_trace_checker.sv
`default_nettype none
// ============================================================================
// Module : fsm_trace_checker
// Lock-step reference checker for the 3-state ring FSM: tracks the observed
// state against its own model and reports the first divergence plus stats.
// Rev    : 1.0  initial release
// ============================================================================
module fsm_trace_checker #(
    parameter int W       = 2,
    parameter int C0      = 0,
    parameter int C1      = 1,
    parameter int C2      = 2,
    parameter int CW      = 8,
    parameter int SYNC_TO = 16,
    parameter int LIMIT   = 10
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          i0_i,
    input  logic          i1_i,
    input  logic          i2_i,
    input  logic          en_i,
    input  logic [W-1:0]  y_i,
    output logic          synced_o,
    output logic          err_o,
    output logic [1:0]    err_code_o,
    output logic [CW-1:0] err_cycle_o,
    output logic [W-1:0]  err_exp_o,
    output logic [W-1:0]  err_obs_o,
    output logic [CW-1:0] cycles_o,
    output logic [CW-1:0] transitions_o,
    output logic          done_o
);

    localparam int SW = (SYNC_TO > 1) ? $clog2(SYNC_TO) : 1;

    localparam logic [W-1:0]  c_S0         = W'(C0);
    localparam logic [W-1:0]  c_S1         = W'(C1);
    localparam logic [W-1:0]  c_S2         = W'(C2);
    localparam logic [SW-1:0] c_SYNC_LAST  = (SYNC_TO > 0) ? SW'(SYNC_TO - 1) : '0;
    localparam logic [CW-1:0] c_TRACK_LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

    localparam logic [1:0] c_CODE_MISMATCH = 2'd1;
    localparam logic [1:0] c_CODE_TIMEOUT  = 2'd2;
    localparam logic [1:0] c_CODE_ILLEGAL  = 2'd3;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    state_t         state_q,      state_d;
    logic [W-1:0]   exp_q,        exp_d;
    logic [SW-1:0]  sync_cnt_q,   sync_cnt_d;
    logic [CW-1:0]  cycles_q,     cycles_d;
    logic [CW-1:0]  trans_q,      trans_d;
    logic [1:0]     err_code_q,   err_code_d;
    logic [CW-1:0]  err_cycle_q,  err_cycle_d;
    logic [W-1:0]   err_exp_q,    err_exp_d;
    logic [W-1:0]   err_obs_q,    err_obs_d;

    logic [W-1:0]   w_exp_next;
    logic [W-1:0]   w_sync_next;
    logic           w_legal;
    logic           w_last;

    // Ring FSM transfer function, shared by the lock-in and tracking paths.
    function automatic logic [W-1:0] f_step(input logic [W-1:0] s,
                                            input logic g0, input logic g1,
                                            input logic g2, input logic adv);
        logic [W-1:0] n;
        n = s;
        if (adv) begin
            if (s == c_S0 && g0)      n = c_S1;
            else if (s == c_S1 && g1) n = c_S2;
            else if (s == c_S2 && g2) n = c_S0;
        end
        return n;
    endfunction

    assign w_exp_next  = f_step(exp_q, i0_i, i1_i, i2_i, en_i);
    assign w_sync_next = f_step(c_S0,  i0_i, i1_i, i2_i, en_i);
    assign w_legal     = (y_i == c_S0) || (y_i == c_S1) || (y_i == c_S2);
    assign w_last      = (LIMIT == 0) || (cycles_q == c_TRACK_LAST);

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        sync_cnt_d  = sync_cnt_q;
        cycles_d    = cycles_q;
        trans_d     = trans_q;
        err_code_d  = err_code_q;
        err_cycle_d = err_cycle_q;
        err_exp_d   = err_exp_q;
        err_obs_d   = err_obs_q;

        case (state_q)
            ST_SYNC: begin
                if (y_i == c_S0) begin
                    state_d = ST_TRACK;
                    exp_d   = w_sync_next;
                end else if (sync_cnt_q == c_SYNC_LAST) begin
                    state_d     = ST_FAIL;
                    err_code_d  = c_CODE_TIMEOUT;
                    err_cycle_d = cycles_q;
                    err_exp_d   = exp_q;
                    err_obs_d   = y_i;
                end else begin
                    sync_cnt_d = sync_cnt_q + SW'(1);
                end
            end
            ST_TRACK: begin
                // Illegal encoding outranks a plain mismatch.
                if (!w_legal || (y_i != exp_q)) begin
                    state_d     = ST_FAIL;
                    err_code_d  = w_legal ? c_CODE_MISMATCH : c_CODE_ILLEGAL;
                    err_cycle_d = cycles_q;
                    err_exp_d   = exp_q;
                    err_obs_d   = y_i;
                end else begin
                    exp_d    = w_exp_next;
                    cycles_d = (&cycles_q) ? cycles_q : cycles_q + CW'(1);
                    if ((w_exp_next != exp_q) && !(&trans_q)) begin
                        trans_d = trans_q + CW'(1);
                    end
                    if (w_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_SYNC;
            exp_q       <= c_S0;
            sync_cnt_q  <= '0;
            cycles_q    <= '0;
            trans_q     <= '0;
            err_code_q  <= '0;
            err_cycle_q <= '0;
            err_exp_q   <= '0;
            err_obs_q   <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            sync_cnt_q  <= sync_cnt_d;
            cycles_q    <= cycles_d;
            trans_q     <= trans_d;
            err_code_q  <= err_code_d;
            err_cycle_q <= err_cycle_d;
            err_exp_q   <= err_exp_d;
            err_obs_q   <= err_obs_d;
        end
    end

    assign synced_o      = (state_q == ST_TRACK) || (state_q == ST_DONE);
    assign err_o         = (state_q == ST_FAIL);
    assign done_o        = (state_q == ST_DONE);
    assign err_code_o    = err_code_q;
    assign err_cycle_o   = err_cycle_q;
    assign err_exp_o     = err_exp_q;
    assign err_obs_o     = err_obs_q;
    assign cycles_o      = cycles_q;
    assign transitions_o = trans_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_trace_checker.sv
`default_nettype none
// ============================================================================
// Module : tb_fsm_trace_checker
// Self-checking bench: a behavioural ring FSM drives y, a reference model of
// the checker predicts every output each cycle.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fsm_trace_checker;

    localparam int P_SYNC  = 0;
    localparam int P_TRACK = 1;
    localparam int P_DONE  = 2;
    localparam int P_FAIL  = 3;
    localparam int LIM     = 10;
    localparam int STO     = 16;

    logic       clk;
    logic       rst_n;
    logic       i0, i1, i2, en;
    logic [1:0] y;

    logic       synced, err, done;
    logic [1:0] ecode, eexp, eobs;
    logic [7:0] ecyc, cyc_o, tr_o;

    logic       z_synced, z_err, z_done;
    logic [1:0] z_ecode, z_eexp, z_eobs;
    logic [7:0] z_ecyc, z_cyc, z_tr;

    int n_checks = 0;
    int n_errs   = 0;
    bit started  = 0;
    int fsm      = 0;

    int m_phase, m_exp, m_sync, m_cyc, m_tr, m_code, m_ecyc, m_eexp, m_eobs;

    fsm_trace_checker #(.LIMIT(LIM), .SYNC_TO(STO)) u_dut (
        .clock_i(clk), .reset_n_i(rst_n),
        .i0_i(i0), .i1_i(i1), .i2_i(i2), .en_i(en), .y_i(y),
        .synced_o(synced), .err_o(err), .err_code_o(ecode),
        .err_cycle_o(ecyc), .err_exp_o(eexp), .err_obs_o(eobs),
        .cycles_o(cyc_o), .transitions_o(tr_o), .done_o(done)
    );

    fsm_trace_checker #(.LIMIT(0)) u_dut_l0 (
        .clock_i(clk), .reset_n_i(rst_n),
        .i0_i(i0), .i1_i(i1), .i2_i(i2), .en_i(en), .y_i(y),
        .synced_o(z_synced), .err_o(z_err), .err_code_o(z_ecode),
        .err_cycle_o(z_ecyc), .err_exp_o(z_eexp), .err_obs_o(z_eobs),
        .cycles_o(z_cyc), .transitions_o(z_tr), .done_o(z_done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Ring rule: advance to the next state when enabled and its guard is set.
    function automatic int ref_next(int s, bit g0, bit g1, bit g2, bit e);
        bit g[3];
        g = '{g0, g1, g2};
        if (!e || s > 2) return s;
        return g[s] ? (s + 1) % 3 : s;
    endfunction

    function automatic int sat(int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic capture(input int code);
        m_phase = P_FAIL;
        m_code  = code;
        m_ecyc  = m_cyc;
        m_eexp  = m_exp;
        m_eobs  = int'(y);
    endtask

    // Checker reference model.
    always @(posedge clk) begin
        int nxt;
        started = 1;
        if (!rst_n) begin
            m_phase = P_SYNC; m_exp = 0; m_sync = 0; m_cyc = 0; m_tr = 0;
            m_code = 0; m_ecyc = 0; m_eexp = 0; m_eobs = 0;
        end else if (m_phase == P_SYNC) begin
            if (y == 2'd0) begin
                m_phase = P_TRACK;
                m_exp   = ref_next(0, i0, i1, i2, en);
            end else if (m_sync == STO - 1) capture(2);
            else m_sync++;
        end else if (m_phase == P_TRACK) begin
            if (y > 2'd2)                 capture(3);
            else if (int'(y) != m_exp)    capture(1);
            else begin
                nxt = ref_next(m_exp, i0, i1, i2, en);
                if (nxt != m_exp) m_tr = sat(m_tr + 1);
                m_exp = nxt;
                m_cyc = sat(m_cyc + 1);
                if (m_cyc >= LIM) m_phase = P_DONE;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit ok;
            ok = (synced == (m_phase == P_TRACK || m_phase == P_DONE)) &&
                 (err == (m_phase == P_FAIL)) && (done == (m_phase == P_DONE)) &&
                 (int'(ecode) == m_code) && (int'(ecyc) == m_ecyc) &&
                 (int'(eexp) == m_eexp) && (int'(eobs) == m_eobs) &&
                 (int'(cyc_o) == m_cyc) && (int'(tr_o) == m_tr);
            n_checks++;
            if (!ok) begin
                n_errs++;
                $display("FAIL cycle_cmp t=%0t got syn=%b err=%b done=%b code=%0d ecyc=%0d eexp=%0d eobs=%0d cyc=%0d tr=%0d want phase=%0d code=%0d ecyc=%0d eexp=%0d eobs=%0d cyc=%0d tr=%0d",
                         $time, synced, err, done, ecode, ecyc, eexp, eobs, cyc_o, tr_o,
                         m_phase, m_code, m_ecyc, m_eexp, m_eobs, m_cyc, m_tr);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_errs++;
            $display("FAIL %s got=%0d want=%0d", nm, act, want);
        end
    endtask

    // One clock: drive guards and y (FSM value unless overridden), step the FSM.
    task automatic cyc(input bit g0, input bit g1, input bit g2, input bit e,
                       input bit ov, input logic [1:0] ovv);
        logic r;
        i0 = g0; i1 = g1; i2 = g2; en = e;
        y  = ov ? ovv : 2'(fsm);
        r  = rst_n;
        @(posedge clk);
        #1;
        fsm = r ? ref_next(fsm, g0, g1, g2, e) : 0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 0;
        repeat (n) cyc(1, 1, 1, 1, 0, 2'd0);
        rst_n = 1;
    endtask

    function automatic bit at_track(int k);
        return (m_phase == P_TRACK) && (m_cyc == k);
    endfunction

    initial begin
        bit g0, g1, g2, e;
        rst_n = 0; i0 = 0; i1 = 0; i2 = 0; en = 0; y = 2'd0;

        // Clean ring run.
        do_reset(16);
        chk("reset_synced", int'(synced), 0);
        chk("reset_err", int'(err), 0);
        repeat (14) cyc(1, 1, 1, 1, 0, 2'd0);
        chk("a_done", int'(done), 1);
        chk("a_cycles", int'(cyc_o), 10);
        chk("a_trans", int'(tr_o), 10);
        chk("a_err", int'(err), 0);
        chk("l0_done", int'(z_done), 1);
        chk("l0_cycles", int'(z_cyc), 1);
        chk("l0_trans", int'(z_tr), 1);

        // Mismatch: y forced to C2 where C1 is expected.
        do_reset(2);
        repeat (14) cyc(1, 1, 1, 1, at_track(3), 2'd2);
        chk("b_code", int'(ecode), 1);
        chk("b_ecyc", int'(ecyc), 3);
        chk("b_eexp", int'(eexp), 1);
        chk("b_eobs", int'(eobs), 2);
        chk("b_cycles_frozen", int'(cyc_o), 3);

        // Sync timeout with y held at C1.
        do_reset(2);
        repeat (20) cyc(1, 1, 1, 1, 1, 2'd1);
        chk("c_code", int'(ecode), 2);
        chk("c_synced", int'(synced), 0);
        chk("c_err", int'(err), 1);

        // Enable low for TRACK cycles 2..5.
        do_reset(2);
        repeat (16) cyc(1, 1, 1, !(m_phase == P_TRACK && m_cyc >= 2 && m_cyc <= 5), 0, 2'd0);
        chk("d_done", int'(done), 1);
        chk("d_trans", int'(tr_o), 6);

        // Illegal encoding.
        do_reset(2);
        repeat (12) cyc(1, 1, 1, 1, at_track(5), 2'd3);
        chk("e_code", int'(ecode), 3);
        chk("e_eexp", int'(eexp), 0);
        chk("e_ecyc", int'(ecyc), 5);

        // One-cycle reset after FAIL, then a clean rerun.
        rst_n = 0;
        cyc(1, 1, 1, 1, 0, 2'd0);
        chk("f_err", int'(err), 0);
        chk("f_code", int'(ecode), 0);
        chk("f_done", int'(done), 0);
        chk("f_cycles", int'(cyc_o), 0);
        rst_n = 1;
        repeat (14) cyc(1, 1, 1, 1, 0, 2'd0);
        chk("f_done_rerun", int'(done), 1);
        chk("f_trans_rerun", int'(tr_o), 10);

        // Randomized episodes: late lock, faults, gated enable, mid-run resets.
        for (int ep = 0; ep < 40; ep++) begin
            int hold;
            logic [1:0] hv;
            do_reset($urandom_range(1, 3));
            hold = $urandom_range(0, 20);
            hv   = 2'($urandom_range(1, 2));
            for (int c = 0; c < 30; c++) begin
                g0 = 1'($urandom); g1 = 1'($urandom); g2 = 1'($urandom);
                e  = ($urandom_range(0, 3) != 0);
                if (c < hold)                        cyc(g0, g1, g2, e, 1, hv);
                else if ($urandom_range(0, 24) == 0) cyc(g0, g1, g2, e, 1, 2'($urandom_range(0, 3)));
                else                                 cyc(g0, g1, g2, e, 0, 2'd0);
                rst_n = ($urandom_range(0, 59) != 0);
            end
            rst_n = 1;
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
